// File: rtl/vga_video_core.sv
// vga_video_core: VGA timing generator with a pixel-clock divider, a
// latency-matched sync/blanking pipeline and colour expansion to 8 bits.
//
// Ports
//   CLOCK_50     in   system clock, all logic on its rising edge
//   reset        in   synchronous active-high reset
//   rgb_in       in   {R,G,B} colour from graphics, COLOR_BITS per channel
//   pixel_x/y    out  current horizontal/vertical counter values
//   pixel_tick   out  one-clock pulse every PIX_DIV clocks
//   video_on     out  counters inside the active area (undelayed)
//   frame_start  out  pulse on the tick at pixel_x=0, pixel_y=0
//   VGA_HS/VS    out  syncs delayed to line up with the colour output
//   VGA_R/G/B    out  8-bit expanded colour, blanked outside the active area
module vga_video_core #(
  parameter int   H_ACTIVE   = 640,
  parameter int   H_FP       = 16,
  parameter int   H_SYNC     = 96,
  parameter int   H_BP       = 48,
  parameter int   V_ACTIVE   = 480,
  parameter int   V_FP       = 10,
  parameter int   V_SYNC     = 2,
  parameter int   V_BP       = 33,
  parameter int   PIX_DIV    = 2,
  parameter int   COLOR_BITS = 1,
  parameter int   LAT        = 1,
  parameter logic SYNC_POL   = 1'b0
) (
  input  logic                    CLOCK_50,
  input  logic                    reset,
  input  logic [3*COLOR_BITS-1:0] rgb_in,
  output logic [10:0]             pixel_x,
  output logic [10:0]             pixel_y,
  output logic                    pixel_tick,
  output logic                    video_on,
  output logic                    frame_start,
  output logic                    VGA_HS,
  output logic                    VGA_VS,
  output logic [7:0]              VGA_R,
  output logic [7:0]              VGA_G,
  output logic [7:0]              VGA_B
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int DEPTH   = LAT + 1;

  localparam logic [10:0] H_LAST   = 11'(H_TOTAL - 1);
  localparam logic [10:0] V_LAST   = 11'(V_TOTAL - 1);
  localparam logic [10:0] H_ACT    = 11'(H_ACTIVE);
  localparam logic [10:0] V_ACT    = 11'(V_ACTIVE);
  localparam logic [10:0] HS_BEG   = 11'(H_ACTIVE + H_FP);
  localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [10:0] VS_BEG   = 11'(V_ACTIVE + V_FP);
  localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [2:0]  DIV_LAST = 3'(PIX_DIV - 1);

  logic [2:0]              div_q, div_d;
  logic [10:0]             h_q, h_d;
  logic [10:0]             v_q, v_d;
  logic [DEPTH-1:0]        hs_pipe_q, vs_pipe_q, von_pipe_q;
  logic [3*COLOR_BITS-1:0] rgb_q;
  logic                    hs_raw, vs_raw;

  // MSB-first replication: repeat the channel eight times and keep the top byte.
  function automatic logic [7:0] expand(input logic [COLOR_BITS-1:0] c);
    logic [8*COLOR_BITS-1:0] rep;
    rep = {8{c}};
    return rep[8*COLOR_BITS-1 -: 8];
  endfunction

  // With PIX_DIV=1 the divider stays at 0 == DIV_LAST, so the tick is
  // continuously high; gating with reset keeps it low while in reset.
  assign pixel_tick = (div_q == DIV_LAST) && !reset;

  always_comb begin
    div_d = (div_q == DIV_LAST) ? '0 : div_q + 3'd1;
    h_d   = h_q;
    v_d   = v_q;
    if (pixel_tick) begin
      if (h_q == H_LAST) begin
        h_d = '0;
        v_d = (v_q == V_LAST) ? '0 : v_q + 11'd1;
      end else begin
        h_d = h_q + 11'd1;
      end
    end
  end

  assign hs_raw      = (h_q >= HS_BEG) && (h_q < HS_END);
  assign vs_raw      = (v_q >= VS_BEG) && (v_q < VS_END);
  assign video_on    = (h_q < H_ACT) && (v_q < V_ACT);
  assign frame_start = pixel_tick && (h_q == '0) && (v_q == '0);
  assign pixel_x     = h_q;
  assign pixel_y     = v_q;

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      div_q      <= '0;
      h_q        <= '0;
      v_q        <= '0;
      hs_pipe_q  <= '0;
      vs_pipe_q  <= '0;
      von_pipe_q <= '0;
      rgb_q      <= '0;
    end else begin
      div_q <= div_d;
      h_q   <= h_d;
      v_q   <= v_d;
      if (pixel_tick) begin
        // Shift toward the MSB; the width cast drops the oldest entry and
        // also covers DEPTH=1 without a zero-width slice.
        hs_pipe_q  <= DEPTH'({hs_pipe_q, hs_raw});
        vs_pipe_q  <= DEPTH'({vs_pipe_q, vs_raw});
        von_pipe_q <= DEPTH'({von_pipe_q, video_on});
        rgb_q      <= rgb_in;
      end
    end
  end

  // Sync stages hold an "active" flag; polarity is applied only at the pins.
  assign VGA_HS = hs_pipe_q[DEPTH-1] ? SYNC_POL : ~SYNC_POL;
  assign VGA_VS = vs_pipe_q[DEPTH-1] ? SYNC_POL : ~SYNC_POL;

  assign VGA_R = von_pipe_q[DEPTH-1] ? expand(rgb_q[3*COLOR_BITS-1 -: COLOR_BITS]) : '0;
  assign VGA_G = von_pipe_q[DEPTH-1] ? expand(rgb_q[2*COLOR_BITS-1 -: COLOR_BITS]) : '0;
  assign VGA_B = von_pipe_q[DEPTH-1] ? expand(rgb_q[COLOR_BITS-1 -: COLOR_BITS])   : '0;

endmodule

// File: tb/tb_vga_video_core.sv
// Testbench for vga_video_core: two small-geometry instances driven by a
// latency-modelling graphics source, checked cycle by cycle against a
// position-arithmetic reference model through a scoreboard queue.
module tb_vga_video_core;

  // Instance A: divided pixel clock, 3-bit colour, LAT=2, active-high syncs.
  localparam int   A_HA = 8, A_HFP = 2, A_HS = 3, A_HBP = 2;
  localparam int   A_VA = 4, A_VFP = 1, A_VS = 2, A_VBP = 1;
  localparam int   A_PD = 3, A_CB = 3, A_LAT = 2;
  localparam logic A_POL = 1'b1;
  localparam int   A_W = 3 * A_CB;
  // Instance B: PIX_DIV=1, porches of one, LAT=0, active-low syncs.
  localparam int   B_HA = 8, B_HFP = 1, B_HS = 1, B_HBP = 1;
  localparam int   B_VA = 4, B_VFP = 1, B_VS = 1, B_VBP = 1;
  localparam int   B_PD = 1, B_CB = 1, B_LAT = 0;
  localparam logic B_POL = 1'b0;
  localparam int   B_W = 3 * B_CB;

  localparam int A_HT = A_HA + A_HFP + A_HS + A_HBP;
  localparam int A_VT = A_VA + A_VFP + A_VS + A_VBP;
  localparam int NCYC = 1600;

  typedef struct {
    int ha, hfp, hs, hbp, va, vfp, vs, vbp, pd, cb, lat, pol;
  } cfg_t;

  typedef struct {
    int tick, x, y, von, fs, hs, vs, r, g, b;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           reset;
  logic [A_W-1:0] rgb_a;
  logic [B_W-1:0] rgb_b;

  logic [10:0] px_a, py_a, px_b, py_b;
  logic        tick_a, von_a, fs_a, hs_a, vs_a;
  logic        tick_b, von_b, fs_b, hs_b, vs_b;
  logic [7:0]  r_a, g_a, b_a, r_b, g_b, b_b;

  vga_video_core #(
    .H_ACTIVE(A_HA), .H_FP(A_HFP), .H_SYNC(A_HS), .H_BP(A_HBP),
    .V_ACTIVE(A_VA), .V_FP(A_VFP), .V_SYNC(A_VS), .V_BP(A_VBP),
    .PIX_DIV(A_PD), .COLOR_BITS(A_CB), .LAT(A_LAT), .SYNC_POL(A_POL)
  ) dut_a (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb_a),
    .pixel_x(px_a), .pixel_y(py_a), .pixel_tick(tick_a),
    .video_on(von_a), .frame_start(fs_a),
    .VGA_HS(hs_a), .VGA_VS(vs_a),
    .VGA_R(r_a), .VGA_G(g_a), .VGA_B(b_a)
  );

  vga_video_core #(
    .H_ACTIVE(B_HA), .H_FP(B_HFP), .H_SYNC(B_HS), .H_BP(B_HBP),
    .V_ACTIVE(B_VA), .V_FP(B_VFP), .V_SYNC(B_VS), .V_BP(B_VBP),
    .PIX_DIV(B_PD), .COLOR_BITS(B_CB), .LAT(B_LAT), .SYNC_POL(B_POL)
  ) dut_b (
    .CLOCK_50(clk), .reset(reset), .rgb_in(rgb_b),
    .pixel_x(px_b), .pixel_y(py_b), .pixel_tick(tick_b),
    .video_on(von_b), .frame_start(fs_b),
    .VGA_HS(hs_b), .VGA_VS(vs_b),
    .VGA_R(r_b), .VGA_G(g_b), .VGA_B(b_b)
  );

  logic [23:0] img [0:3][0:7];
  cfg_t        cfg_a, cfg_b;
  exp_t        qa[$], qb[$];
  int          gqa[$], gqb[$];
  int          total = 0;
  int          bad = 0;

  // Channel widened to 8 bits by reading its bits MSB-first, cyclically.
  function automatic int expand(int ch, int cbits);
    int o;
    o = 0;
    for (int i = 0; i < 8; i++)
      o = o * 2 + ((ch >> (cbits - 1 - (i % cbits))) & 1);
    return o;
  endfunction

  function automatic int word_mask(int cbits);
    return (1 << (3 * cbits)) - 1;
  endfunction

  // Expected outputs during clock c after reset release: c/pd ticks have
  // elapsed, and the visible pixel is the one presented lat+1 ticks earlier.
  function automatic exp_t model(cfg_t g, int c, bit rst);
    exp_t e;
    int ht, vt, m, j, hj, vj, w;
    ht = g.ha + g.hfp + g.hs + g.hbp;
    vt = g.va + g.vfp + g.vs + g.vbp;
    m = c / g.pd;
    e.tick = ((c % g.pd) == (g.pd - 1) && !rst) ? 1 : 0;
    e.x = m % ht;
    e.y = (m / ht) % vt;
    e.von = (e.x < g.ha && e.y < g.va) ? 1 : 0;
    e.fs = (e.tick == 1 && e.x == 0 && e.y == 0) ? 1 : 0;
    e.hs = 1 - g.pol;
    e.vs = 1 - g.pol;
    e.r = 0; e.g = 0; e.b = 0;
    j = m - 1 - g.lat;
    if (j >= 0) begin
      hj = j % ht;
      vj = (j / ht) % vt;
      if (hj >= g.ha + g.hfp && hj < g.ha + g.hfp + g.hs) e.hs = g.pol;
      if (vj >= g.va + g.vfp && vj < g.va + g.vfp + g.vs) e.vs = g.pol;
      if (hj < g.ha && vj < g.va) begin
        w = int'(img[vj][hj]) & word_mask(g.cb);
        e.r = expand(w >> (2 * g.cb), g.cb);
        e.g = expand(w >> g.cb, g.cb);
        e.b = expand(w, g.cb);
      end
    end
    return e;
  endfunction

  // Graphics source: image colour inside the active area, junk elsewhere.
  function automatic int gfx(cfg_t g, int x, int y);
    if (x < g.ha && y < g.va) return int'(img[y][x]) & word_mask(g.cb);
    return int'($urandom);
  endfunction

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s at t=%0t: got %0d expected %0d", nm, $time, act, expv);
    end
  endtask

  // Monitor: the video stream is continuous, so one expected record per
  // clock is consumed and compared.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (qa.size() > 0) begin
        e = qa.pop_front();
        chk("A.pixel_tick", int'(tick_a), e.tick);
        chk("A.pixel_x", int'(px_a), e.x);
        chk("A.pixel_y", int'(py_a), e.y);
        chk("A.video_on", int'(von_a), e.von);
        chk("A.frame_start", int'(fs_a), e.fs);
        chk("A.VGA_HS", int'(hs_a), e.hs);
        chk("A.VGA_VS", int'(vs_a), e.vs);
        chk("A.VGA_R", int'(r_a), e.r);
        chk("A.VGA_G", int'(g_a), e.g);
        chk("A.VGA_B", int'(b_a), e.b);
      end
      if (qb.size() > 0) begin
        e = qb.pop_front();
        chk("B.pixel_tick", int'(tick_b), e.tick);
        chk("B.pixel_x", int'(px_b), e.x);
        chk("B.pixel_y", int'(py_b), e.y);
        chk("B.video_on", int'(von_b), e.von);
        chk("B.frame_start", int'(fs_b), e.fs);
        chk("B.VGA_HS", int'(hs_b), e.hs);
        chk("B.VGA_VS", int'(vs_b), e.vs);
        chk("B.VGA_R", int'(r_b), e.r);
        chk("B.VGA_G", int'(g_b), e.g);
        chk("B.VGA_B", int'(b_b), e.b);
      end
    end
  end

  // Driver: reset schedule, graphics latency model and expected-record push.
  initial begin
    int  cnt_a, cnt_b, rst_left;
    bit  did_rst, r;
    cfg_a = '{A_HA, A_HFP, A_HS, A_HBP, A_VA, A_VFP, A_VS, A_VBP, A_PD, A_CB, A_LAT, int'(A_POL)};
    cfg_b = '{B_HA, B_HFP, B_HS, B_HBP, B_VA, B_VFP, B_VS, B_VBP, B_PD, B_CB, B_LAT, int'(B_POL)};
    for (int y = 0; y < 4; y++)
      for (int x = 0; x < 8; x++)
        img[y][x] = 24'($urandom);
    img[0][0] = 24'h000147;  // A: R=101 G=000 B=111; B: 111
    img[1][3] = 24'h000005;  // B: 101
    reset = 1'b1;
    rgb_a = '0;
    rgb_b = '0;
    cnt_a = 0;
    cnt_b = 0;
    rst_left = 3;
    did_rst = 1'b0;
    for (int k = 0; k < NCYC; k++) begin
      @(negedge clk);
      // Mid-frame reset in the second frame of A at h=5, v=2.
      if (!did_rst && rst_left == 0 && cnt_a == A_PD * (A_HT * A_VT + 2 * A_HT + 5) + 1) begin
        rst_left = 3;
        did_rst = 1'b1;
      end
      r = (rst_left > 0);
      if (rst_left > 0) rst_left--;
      reset = r;
      #1;
      if (r) begin
        gqa.delete();
        rgb_a = A_W'($urandom);
      end else if (tick_a) begin
        gqa.push_back(gfx(cfg_a, int'(px_a), int'(py_a)));
        if (gqa.size() > A_LAT) rgb_a = A_W'(gqa.pop_front());
        else rgb_a = A_W'($urandom);
      end else begin
        rgb_a = A_W'($urandom);
      end
      if (r) begin
        gqb.delete();
        rgb_b = B_W'($urandom);
      end else if (tick_b) begin
        gqb.push_back(gfx(cfg_b, int'(px_b), int'(py_b)));
        if (gqb.size() > B_LAT) rgb_b = B_W'(gqb.pop_front());
        else rgb_b = B_W'($urandom);
      end else begin
        rgb_b = B_W'($urandom);
      end
      qa.push_back(model(cfg_a, cnt_a, r));
      qb.push_back(model(cfg_b, cnt_b, r));
      cnt_a = r ? 0 : cnt_a + 1;
      cnt_b = r ? 0 : cnt_b + 1;
    end
    repeat (2) @(negedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/vga_video_core.md
VGA_VIDEO_CORE -- requirements
Module: vga_video_core

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 640, visible pixels per line.
REQ-002 SHALL have parameters H_FP=16, H_SYNC=96, H_BP=48, which set the horizontal porch and sync widths in pixels.
REQ-003 SHALL have parameters V_ACTIVE=480, V_FP=10, V_SYNC=2, V_BP=33, which set the vertical visible, porch and sync lines.
REQ-004 SHALL have parameter PIX_DIV, default 2, clock cycles per pixel tick (legal range 1..8).
REQ-005 SHALL have parameter COLOR_BITS, default 1, bits per colour channel on rgb_in (legal range 1..8).
REQ-006 SHALL have parameter LAT, default 1, graphics latency in pixel ticks from pixel_x/pixel_y to valid rgb_in (legal range 0..4).
REQ-007 SHALL have parameter SYNC_POL, default 0, active level of VGA_HS and VGA_VS.
REQ-008 CLOCK_50  in  1  single system clock; all logic on its rising edge.
REQ-009 reset  in  1  synchronous, active-high reset.
REQ-010 rgb_in  in  3*COLOR_BITS  colour from graphics, packed as {R,G,B}, each channel MSB-first.
REQ-011 pixel_x, pixel_y  out  11 each  current horizontal/vertical counter values driven to graphics.
REQ-012 pixel_tick  out  1  one-clock pulse, once per PIX_DIV clocks.
REQ-013 video_on  out  1  high when counters are inside the active area (undelayed).
REQ-014 frame_start  out  1  one-clock pulse on the tick where pixel_x=0 and pixel_y=0.
REQ-015 VGA_HS, VGA_VS  out  1 each  syncs delayed to align with colour output.
REQ-016 VGA_R, VGA_G, VGA_B  out  8 each  expanded colour, blanked outside the active area.

Function
REQ-017 The divider SHALL count 0..PIX_DIV-1 and assert pixel_tick in the cycle it equals PIX_DIV-1; when PIX_DIV=1, pixel_tick SHALL be constantly high after reset.
REQ-018 On each tick, h_count SHALL increment and wrap from H_TOTAL-1 to 0, where H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP.
REQ-019 On the tick where h_count wraps, v_count SHALL increment and wrap from V_TOTAL-1 to 0; v_count SHALL be unchanged on all other ticks.
REQ-020 Raw hsync SHALL be active for h_count in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1]; raw vsync SHALL use the same rule with the vertical parameters.
REQ-021 video_on SHALL equal (h_count<H_ACTIVE) && (v_count<V_ACTIVE); pixel_x/pixel_y SHALL equal h_count/v_count.
REQ-022 Raw hsync, raw vsync and video_on SHALL pass through a (LAT+1)-stage shift register that advances only on pixel_tick.
REQ-023 rgb_in SHALL be captured on the pixel_tick cycle into the output register; the output register SHALL also advance only on pixel_tick.
REQ-024 Each channel SHALL expand to 8 bits by MSB-first bit replication, truncated to 8 bits (1 bit: 1 -> 0xFF; 3 bits: 101 -> 0xB6; 8 bits: unchanged).
REQ-025 When delayed video_on is low, VGA_R/G/B SHALL be 0 regardless of rgb_in.
REQ-026 VGA_HS/VGA_VS SHALL equal SYNC_POL when the delayed sync is active, and ~SYNC_POL otherwise.
REQ-027 Net alignment: pixel (x,y) sampled from rgb_in SHALL appear on VGA_* in the same tick as that pixel's sync and blanking state.
REQ-028 Outputs SHALL change only on clocks where pixel_tick=1; there SHALL be no glitches between ticks.

Reset
REQ-029 While reset=1: divider, h_count and v_count SHALL be 0.
REQ-030 While reset=1: all delay stages SHALL hold the inactive sync level and video_on=0.
REQ-031 While reset=1: VGA_R/G/B=0, VGA_HS=VGA_VS=~SYNC_POL, and pixel_tick=frame_start=0.
REQ-032 Reset asserted mid-frame SHALL take effect on the next clock edge; the first pixel_tick after release SHALL occur PIX_DIV clocks later, with pixel_x=0, pixel_y=0.

Verification
REQ-033 Defaults, reset released: pixel_tick every 2 clocks; hsync low for exactly 96 ticks starting at h=656; line period 800 ticks; frame period 525 lines = 840000 clocks.
REQ-034 COLOR_BITS=3, rgb_in={3'b101,3'b000,3'b111} during active area -> VGA_R=0xB6, VGA_G=0x00, VGA_B=0xFF; at h>=640 -> all outputs 0.
REQ-035 LAT=2, graphics model returns rgb=x[2:0] two ticks late -> VGA_R shows x-pattern with no offset relative to the hsync edge (first visible pixel after blanking is x=0).
REQ-036 SYNC_POL=1 -> VGA_HS/VGA_VS idle at 0 and high during sync; after reset both are 0.
REQ-037 reset pulsed at h=300, v=200 -> next clock: counters 0, colour 0; frame_start pulses on the first tick after release.
REQ-038 PIX_DIV=1, H_ACTIVE=8, all porches=1, V_ACTIVE=4 -> h wraps 10->0 each 11 clocks; frame_start period 11*7=77 clocks.
